// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths, register-address constants and typedefs for the
//            decode, data-memory and write-back stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/regfile_array.sv
// ============================================================================
// Module   : regfile_array
// Purpose  : 2**ADDR_W x DATA_W register storage, one write port, two
//            combinational read ports, register 0 hardwired to zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int NUM = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Entry 0 is never written, but force the read anyway so zero never depends on storage.
    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/write_back_regfile.sv
// ============================================================================
// Module   : write_back_regfile
// Purpose  : Write-back latch, register file commit, registered read ports
//            and committed-write counter. Macro WB_BYPASS_EN enables
//            write-through of the committing value to the read ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module write_back_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mux_ans_dm,
    input  logic [ADDR_W-1:0] RW_dm,
    input  logic              wb_en_dm,
    input  logic [ADDR_W-1:0] RA_id,
    input  logic [ADDR_W-1:0] RB_id,
    output logic [DATA_W-1:0] A_rf,
    output logic [DATA_W-1:0] B_rf,
    output logic [DATA_W-1:0] ans_wb,
    output logic [ADDR_W-1:0] RW_wb,
    output logic              wb_en_wb,
    output logic [15:0]       wr_count
);

    import wb_pkg::*;

    logic [DATA_W-1:0] ans_q;
    logic [ADDR_W-1:0] rw_q;
    logic              en_q;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;
    logic              w_commit;

    assign w_commit = en_q && (rw_q != ADDR_W'(REG_ZERO));

    regfile_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst       (reset),
        .we_i      (w_commit),
        .waddr_i   (rw_q),
        .wdata_i   (ans_q),
        .raddr_a_i (RA_id),
        .raddr_b_i (RB_id),
        .rdata_a_o (w_rd_a),
        .rdata_b_o (w_rd_b)
    );

    always_comb begin
        a_d   = w_rd_a;
        b_d   = w_rd_b;
        cnt_d = w_commit ? (cnt_q + 16'd1) : cnt_q;
`ifdef WB_BYPASS_EN
        if (w_commit && (RA_id == rw_q)) a_d = ans_q;
        if (w_commit && (RB_id == rw_q)) b_d = ans_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ans_q <= '0;
            rw_q  <= '0;
            en_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            ans_q <= mux_ans_dm;
            rw_q  <= RW_dm;
            en_q  <= wb_en_dm;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign A_rf     = a_q;
    assign B_rf     = b_q;
    assign ans_wb   = ans_q;
    assign RW_wb    = rw_q;
    assign wb_en_wb = en_q;
    assign wr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_write_back_regfile.sv
// ============================================================================
// Module   : tb_write_back_regfile
// Purpose  : Directed self-checking bench for write_back_regfile; expected
//            read-after-commit values follow WB_BYPASS_EN when defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_write_back_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mux_ans_dm;
    logic [4:0]  RW_dm;
    logic        wb_en_dm;
    logic [4:0]  RA_id;
    logic [4:0]  RB_id;
    logic [7:0]  A_rf;
    logic [7:0]  B_rf;
    logic [7:0]  ans_wb;
    logic [4:0]  RW_wb;
    logic        wb_en_wb;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    write_back_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .mux_ans_dm (mux_ans_dm),
        .RW_dm      (RW_dm),
        .wb_en_dm   (wb_en_dm),
        .RA_id      (RA_id),
        .RB_id      (RB_id),
        .A_rf       (A_rf),
        .B_rf       (B_rf),
        .ans_wb     (ans_wb),
        .RW_wb      (RW_wb),
        .wb_en_wb   (wb_en_wb),
        .wr_count   (wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [4:0] rw, input logic en);
        mux_ans_dm = d;
        RW_dm      = rw;
        wb_en_dm   = en;
    endtask

    logic [7:0] same_edge_exp;

    initial begin
`ifdef WB_BYPASS_EN
        same_edge_exp = 8'h22;
`else
        same_edge_exp = 8'h11;
`endif
        reset = 1'b1;
        drive(8'h00, 5'd0, 1'b0);
        RA_id = 5'd0;
        RB_id = 5'd0;
        repeat (3) tick();

        check("rst_A", A_rf, 0);
        check("rst_B", B_rf, 0);
        check("rst_ans", ans_wb, 0);
        check("rst_RW", RW_wb, 0);
        check("rst_en", wb_en_wb, 0);
        check("rst_cnt", wr_count, 0);

        // Basic write then read of R31
        reset = 1'b0;
        drive(8'h50, 5'h1F, 1'b1);
        tick();
        check("wbl_ans", ans_wb, 8'h50);
        check("wbl_RW", RW_wb, 5'h1F);
        check("wbl_en", wb_en_wb, 1);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        RA_id = 5'h1F;
        tick();
        check("rd_r31", A_rf, 8'h50);
        check("cnt_1", wr_count, 1);

        // Writes to R0 are dropped and uncounted
        drive(8'hAA, 5'd0, 1'b1);
        tick();
        drive(8'h00, 5'd0, 1'b0);
        tick();
        RA_id = 5'd0;
        tick();
        check("rd_r0", A_rf, 0);
        check("cnt_r0", wr_count, 1);

        // Same-edge read of a committing register
        drive(8'h11, 5'd3, 1'b1);
        tick();
        drive(8'h00, 5'd0, 1'b0);
        tick();
        drive(8'h22, 5'd3, 1'b1);
        tick();
        drive(8'h00, 5'd0, 1'b0);
        RA_id = 5'd3;
        RB_id = 5'd3;
        tick();
        check("same_A", A_rf, same_edge_exp);
        check("same_B", B_rf, same_edge_exp);
        check("cnt_3", wr_count, 3);
        tick();
        check("after_A", A_rf, 8'h22);
        check("after_B", B_rf, 8'h22);

        // Disabled write leaves R4 alone
        drive(8'h44, 5'd4, 1'b1);
        tick();
        drive(8'h99, 5'd4, 1'b0);
        tick();
        tick();
        drive(8'h00, 5'd0, 1'b0);
        RA_id = 5'd4;
        tick();
        tick();
        check("r4_kept", A_rf, 8'h44);
        check("cnt_4", wr_count, 4);

        // Mid-run reset discards in-flight WB latch
        drive(8'h77, 5'd5, 1'b1);
        tick();
        check("inflight", ans_wb, 8'h77);
        reset = 1'b1;
        #1;
        check("mrst_ans", ans_wb, 0);
        check("mrst_en", wb_en_wb, 0);
        check("mrst_cnt", wr_count, 0);
        check("mrst_A", A_rf, 0);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
        RA_id = 5'd5;
        RB_id = 5'd3;
        tick();
        tick();
        check("r5_zero", A_rf, 0);
        check("r3_cleared", B_rf, 0);
        check("cnt_post", wr_count, 0);

        // Counter wrap: 65536 committed writes to R1
        for (int i = 0; i < 65536; i++) begin
            drive(i[7:0], 5'd1, 1'b1);
            tick();
        end
        check("cnt_ffff", wr_count, 16'hFFFF);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        check("cnt_wrap", wr_count, 16'h0000);
        RA_id = 5'd1;
        tick();
        check("r1_last", A_rf, 8'hFF);
        check("cnt_hold", wr_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/write_back_regfile.md
# write_back_regfile

Write-back stage and general-purpose register file of the 8-bit pipelined MIPS core. It is the consumer of the data-memory stage: it latches the selected memory/ALU result and destination register from that stage and commits it to a 32-entry register file one cycle later. It also serves the decode stage's two registered read ports, and exports the write-back latch contents for EX-stage forwarding.

## Interface
Parameters:
- DATA_W, 8, register/data width
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- mux_ans_dm  input  DATA_W  result selected by data-memory stage
- RW_dm  input  ADDR_W  destination register from data-memory stage
- wb_en_dm  input  1  destination write enable from data-memory stage
- RA_id  input  ADDR_W  read address A from decode
- RB_id  input  ADDR_W  read address B from decode
- A_rf  output  DATA_W  registered read data A
- B_rf  output  DATA_W  registered read data B
- ans_wb  output  DATA_W  write-back latch data (forwarding source)
- RW_wb  output  ADDR_W  write-back latch destination
- wb_en_wb  output  1  write-back latch enable
- wr_count  output  16  committed-write counter (debug)

## Operation
- WB latch: every edge, ans_wb/RW_wb/wb_en_wb <= mux_ans_dm/RW_dm/wb_en_dm. No stall input; the stage always advances.
- Commit: every edge, if wb_en_wb=1 and RW_wb!=0, regs[RW_wb] <= ans_wb and wr_count <= wr_count+1 (16-bit, wraps 0xFFFF->0x0000).
- Register 0: hardwired zero; writes to it are dropped and not counted; reads return 0.
- Reads: every edge, A_rf <= rd(RA_id), B_rf <= rd(RB_id), where rd() returns the array contents before the edge (or the bypassed value, see Configuration).
- Both read ports may address the same register, including the one being committed; both return identical data.
- No X propagation: all 32 entries are defined from reset.

## Timing
- Reset (async assert, sync-safe deassert by system): A_rf, B_rf, ans_wb = 0; RW_wb = 0; wb_en_wb = 0; wr_count = 0; all registers = 0.
- Reset mid-operation: the in-flight WB latch content is discarded, never committed.
- Result presented at DM stage before edge n -> in WB latch after edge n -> in array after edge n+1.
- Read address sampled at edge k -> A_rf/B_rf valid after edge k (1-cycle latency).
- A write still in the DM stage at edge k is never visible at the read port at edge k; EX forwarding via ans_wb/RW_wb covers it.

## Configuration
- WB_BYPASS_EN defined: write-through; if read address equals RW_wb, wb_en_wb=1 and RW_wb!=0 at edge k, the port captures ans_wb (the value committed at that same edge).
- WB_BYPASS_EN undefined: the port captures the pre-edge array value; software/hazard unit must insert one bubble between a write-back and a dependent decode-stage read.

## Structure
- Shared package wb_pkg: DATA_W, ADDR_W, NUM_REGS constants, REG_ZERO = 0 address constant, and reg_addr_t/data_t typedefs, shared with the decode and data-memory stages.
- One sub-module, regfile_array: 32xDATA_W storage, one write port, two combinational read ports, with register 0 forced to zero. The WB latch, bypass muxes, output registers and counter stay in the top.

## Test plan
- Reset: assert reset mid-run with wb_en_dm=1 -> all outputs 0, and reading R5 returns 0x00 after deassert.
- Write/read: mux_ans_dm=0x50, RW_dm=0x1F, wb_en_dm=1 at edge 1 -> ans_wb=0x50 after edge 1; RA_id=0x1F at edge 3 -> A_rf=0x50, wr_count=1.
- Register 0: write 0xAA to R0 -> A_rf=0x00 on later read; wr_count unchanged.
- Same-edge read: R3 holds 0x11; 0x22 to R3 in WB latch while RA_id=RB_id=3 -> A_rf=B_rf=0x22 with WB_BYPASS_EN, 0x11 without it.
- wb_en_dm=0 with RW_dm=0x04, mux_ans_dm=0x99 -> R4 unchanged and wr_count unchanged.
- Counter wrap: preload via 65536 consecutive writes to R1 -> wr_count returns to 0x0000; R1 holds the last value.
